// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Saturation limits are returned wide and narrowed by the caller to its own width.
package addsub_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;
   localparam int MAX_WIDTH      = 256;

   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
      return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] max_neg(input int width);
      return MAX_WIDTH'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/addsub_segment.sv
// One carry-chain segment: SEG-bit add with carry-in.
// Also exposes the carry into the segment MSB for signed-overflow detection.
module addsub_segment
   import addsub_pkg::*;
#(
   parameter int SEG = seg_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           c_msb
);

   logic [SEG:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   assign sum   = total[SEG-1:0];
   assign cout  = total[SEG];
   // a ^ b ^ sum at the MSB recovers the carry that entered that bit
   assign c_msb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one carry segment per stage, valid/ready on both sides.
// Optional build macro ADDSUB_SATURATE_EN clamps the result on signed overflow.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int SEG  = seg_width(WIDTH, STAGES);
   localparam int LAST = STAGES - 1;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0) || (WIDTH > MAX_WIDTH)) begin : g_bad_params
      $error("pipelined_addsub: illegal WIDTH/STAGES combination");
   end

   // x_q holds the unconsumed A segments in its low part and the finished sum
   // segments in its high part; each stage shifts one A segment out and one sum
   // segment in, so after the last stage x_q is exactly the aligned sum.
   logic [WIDTH-1:0] x_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic             c_q     [STAGES];
   logic             v_q     [STAGES];
   logic             ov_q;

   logic [WIDTH-1:0] a_in    [STAGES];
   logic [WIDTH-1:0] b_in    [STAGES];
   logic             c_in    [STAGES];
   logic             v_in    [STAGES];
   logic [WIDTH-1:0] x_shift [STAGES];
   logic [WIDTH-1:0] x_nxt   [STAGES];
   logic [SEG-1:0]   seg_s   [STAGES];
   logic             seg_co  [STAGES];
   logic             seg_cm  [STAGES];

   logic             stall;
   logic             ov_nxt;
   logic             unused_b;

   assign stall    = v_q[LAST] && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign a_in[k] = a;
         assign b_in[k] = sub ? ~b : b;
         assign c_in[k] = sub;
         assign v_in[k] = in_valid;
      end else begin : g_next
         assign a_in[k] = x_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign v_in[k] = v_q[k-1];
      end

      addsub_segment #(
         .SEG (SEG)
      ) u_seg (
         .a     (a_in[k][SEG-1:0]),
         .b     (b_in[k][SEG-1:0]),
         .cin   (c_in[k]),
         .sum   (seg_s[k]),
         .cout  (seg_co[k]),
         .c_msb (seg_cm[k])
      );

      assign x_shift[k] = (a_in[k] >> SEG) | (WIDTH'(seg_s[k]) << (WIDTH - SEG));

      if (k < LAST) begin : g_mid
         assign x_nxt[k] = x_shift[k];
      end
   end

   assign ov_nxt = seg_co[LAST] ^ seg_cm[LAST];

`ifdef ADDSUB_SATURATE_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(max_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(max_neg(WIDTH));

   // Overflow only occurs when both operand signs agree, so A's sign picks the rail.
   assign x_nxt[LAST] = !ov_nxt           ? x_shift[LAST] :
                        a_in[LAST][SEG-1] ? SAT_NEG       : SAT_POS;
`else
   assign x_nxt[LAST] = x_shift[LAST];
`endif

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            x_q[k] <= '0;
            b_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         ov_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_in[k];
            x_q[k] <= x_nxt[k];
            b_q[k] <= b_in[k] >> SEG;
            c_q[k] <= seg_co[k];
         end
         ov_q <= ov_nxt;
      end
   end

   // the final stage's B copy has no consumer
   assign unused_b = ^b_q[LAST];

   assign out_valid = v_q[LAST];
   assign sum       = x_q[LAST];
   assign carry_out = c_q[LAST];
   assign overflow  = ov_q;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the single-cycle 32-bit combinational adder in the 5-stage datapath.
- Splits the carry chain into STAGES segments, one segment per clock, so the ALU/branch-target path can run at higher clock rates.
- Valid/ready handshake at input and output. Signed overflow and carry-out reported with every result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry-chain segments; 1 ≤ STAGES ≤ WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  unsigned carry out of MSB (for sub, 1 = no borrow).
- overflow  output  1  signed overflow.

Behaviour:
- Reset: when Rst_n = 0 at a rising edge, clear all stage valid bits. out_valid=0, sum=0, carry_out=0, overflow=0. Reset mid-operation discards all in-flight beats; in_ready=1 in the first cycle after reset.
- Segment width SEG = WIDTH/STAGES. Subtraction is implemented as A + ~B with carry-in 1.
- Stage k (0..STAGES-1) adds segment k of A and the effective B plus the carry registered by stage k-1. Stage 0 uses carry-in = sub.
- Unprocessed upper segments travel forward with the beat. Completed lower segments are delayed so the full sum emerges aligned.
- Latency: exactly STAGES cycles from an accepted input beat to out_valid, assuming no stall. Throughput: 1 beat per cycle.
- Handshake:
  - Input beat is accepted when in_valid && in_ready.
  - Output beat is consumed when out_valid && out_ready.
  - Global stall = out_valid && !out_ready. in_ready = !stall.
  - During a stall every stage register holds its value. Bubbles are not compressed.
  - sum, carry_out and overflow stay stable while out_valid && !out_ready.
- Flags, computed in the final stage:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Simultaneous accept and consume in the same cycle is legal and sustains full throughput.
- in_valid=0 inserts a bubble. Output data on bubble cycles is don't-care, but out_valid must be 0.
- STAGES=1 degenerates to one registered full-width add with 1-cycle latency.
- Wrap-around: the sum is modulo 2^WIDTH unless saturation is enabled.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- When defined: on overflow=1, sum is clamped. Positive overflow (A sign bit = effective B sign bit = 0) gives 0111…1; negative overflow gives 1000…0. The overflow flag is still reported. Latency is unchanged; the clamp is applied in the final stage.
- When undefined: wrap-around result with no clamp logic.

Decomposition:
- Package addsub_pkg holds:
  - constants DEFAULT_WIDTH=32 and DEFAULT_STAGES=4;
  - function seg_width(width, stages);
  - saturation constants functions max_pos(width) and max_neg(width).
- Sub-module addsub_segment: SEG-bit combinational add with carry-in. Outputs the segment sum, carry-out, and carry into its MSB (used for the overflow calculation in the top segment).
- Top level generates STAGES instances plus the stage registers and the valid/stall logic.

Test Plan:
- WIDTH=32, STAGES=4: a=0x0000_FFFF, b=0x0000_0001, sub=0 → after 4 cycles sum=0x0001_0000, carry_out=0, overflow=0. The carry must cross the segment boundary.
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 → sum=0x8000_0000, overflow=1. With ADDSUB_SATURATE_EN: sum=0x7FFF_FFFF, overflow=1.
- a=5, b=7, sub=1 → sum=0xFFFF_FFFE, carry_out=0, overflow=0. a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, overflow=1 (saturated build: 0x8000_0000).
- Back-to-back stream of 8 beats with out_ready=1 → 8 results on consecutive cycles in order, first result 4 cycles after the first accept.
- out_ready held 0 for 3 cycles while the pipeline is full → in_ready=0, output held stable, no beat lost or duplicated; release → in-order drain.
- Rst_n=0 for one cycle with 3 beats in flight → next cycle out_valid=0, in_ready=1, all outputs 0; no stale beat ever emerges.
